// File: rtl/dut_stim_harness_pkg.sv
// Shared types and word counts for the DUT stimulus/response harness.
package dut_stim_harness_pkg;

  localparam int unsigned VEC_WORDS = 3;
  localparam int unsigned RSP_WORDS = 4;
  localparam int unsigned WIDX_W    = 2;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

  typedef logic [WIDX_W-1:0] widx_t;

  // True when idx addresses the final word of an n-word sequence.
  function automatic logic is_last_word(input widx_t idx, input int unsigned n);
    return idx == widx_t'(n - 1);
  endfunction

endpackage

// File: rtl/dut_stim_harness_ser.sv
// Response serializer: holds {probe, result} and emits it LSB word first on a
// valid/ready stream, flagging the final word.
module dut_stim_harness_ser
  import dut_stim_harness_pkg::*;
#(
  parameter int unsigned VEC_W  = 96,
  parameter int unsigned WORD_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [VEC_W+WORD_W-1:0] load_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WORD_W-1:0]       m_word,
  output logic                    m_last,
  output logic                    done_c
);

  localparam int unsigned RSP_W = VEC_W + WORD_W;

  logic [RSP_W-1:0] rsp_q;
  widx_t            idx_q;
  logic             valid_q;
  logic             last_q;
  logic             fire_c;

  assign fire_c  = valid_q & m_ready;
  assign done_c  = fire_c & is_last_word(idx_q, RSP_WORDS);
  assign m_valid = valid_q;
  assign m_word  = rsp_q[WORD_W-1:0];
  assign m_last  = last_q;

  // The current word always sits in the low slot; a handshake shifts the next one down.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      rsp_q   <= load_data;
      idx_q   <= '0;
      valid_q <= 1'b1;
      last_q  <= 1'b0;
    end else if (fire_c) begin
      rsp_q <= rsp_q >> WORD_W;
      if (done_c) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        idx_q  <= idx_q + widx_t'(1);
        last_q <= is_last_word(idx_q + widx_t'(1), RSP_WORDS);
      end
    end
  end

endmodule

// File: rtl/dut_stim_harness.sv
// Stimulus/response harness: assembles 3-word vectors onto the DUT input,
// waits a programmable settle time, captures the DUT result and streams it back.
module dut_stim_harness
  import dut_stim_harness_pkg::*;
#(
  parameter int unsigned VEC_W    = 96,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned SETTLE_W = 4
) (
  input  logic                clkin_data,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WORD_W-1:0]   s_word,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [VEC_W-1:0]    drive_data,
  input  logic [VEC_W-1:0]    sample_data,
  input  logic [WORD_W-1:0]   probe_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WORD_W-1:0]   m_word,
  output logic                m_last,
  output logic                busy
);

  state_t              state_q;
  state_t              state_d;
  widx_t               widx_q;
  logic                run_q;
  logic [VEC_W-1:0]    shadow_q;
  logic [VEC_W-1:0]    drive_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic                accept_c;
  logic                last_c;
  logic                capture_c;
  logic                done_c;

  // run_q keeps s_ready low through reset without a path from the rst pin.
  assign s_ready    = run_q & (state_q == LOAD);
  assign busy       = (state_q != LOAD);
  assign drive_data = drive_q;
  assign accept_c   = s_valid & s_ready;
  assign last_c     = accept_c & is_last_word(widx_q, VEC_WORDS);

  always_ff @(posedge clkin_data) begin
    if (rst) begin
      state_q <= LOAD;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    case (state_q)
      LOAD: begin
        if (last_c) begin
          state_d = (settle_cycles != '0) ? SETTLE : CAPTURE;
        end
      end
      SETTLE: begin
        if (cnt_q <= SETTLE_W'(1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        capture_c = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (done_c) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Words gather in the shadow; drive_data only moves once the whole vector is in.
  always_ff @(posedge clkin_data) begin
    if (rst) begin
      widx_q   <= '0;
      shadow_q <= '0;
      drive_q  <= '0;
    end else if (accept_c) begin
      for (int k = 0; k < int'(VEC_WORDS); k++) begin
        if (widx_q == widx_t'(k)) begin
          shadow_q[k*WORD_W +: WORD_W] <= s_word;
        end
      end
      if (last_c) begin
        drive_q <= {s_word, shadow_q[VEC_W-WORD_W-1:0]};
        widx_q  <= '0;
      end else begin
        widx_q <= widx_q + widx_t'(1);
      end
    end
  end

  always_ff @(posedge clkin_data) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (last_c) begin
      cnt_q <= settle_cycles;
    end else if (state_q == SETTLE) begin
      cnt_q <= cnt_q - SETTLE_W'(1);
    end
  end

  dut_stim_harness_ser #(
    .VEC_W  (VEC_W),
    .WORD_W (WORD_W)
  ) u_ser (
    .clk       (clkin_data),
    .rst       (rst),
    .load      (capture_c),
    .load_data ({probe_in, sample_data}),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_word    (m_word),
    .m_last    (m_last),
    .done_c    (done_c)
  );

endmodule
